// File: rtl/msu_data_buffer_pkg.sv
// Shared sizing constants for the MSU-1 data stream window buffer.
// The helper function keeps the depth tied to the address width everywhere.
package msu_data_buffer_pkg;

    localparam int MSU_BUF_ADDR_W = 14;
    localparam int MSU_BUF_DATA_W = 8;
    localparam int MSU_BUF_DEPTH  = 16384;

    // Depth is always exactly 2**aw. A zero or negative width still gives a one-entry array.
    function automatic int msu_buf_depth(input int aw);
        if (aw < 1) begin
            return 1;
        end
        return 1 << aw;
    endfunction

endpackage

// File: rtl/msu_bram_sdp.sv
// Generic simple-dual-port RAM with a registered read port and read-first collision behaviour.
// rd_clr synchronously clears the read register and maps onto the block RAM output-register reset.
module msu_bram_sdp
    import msu_data_buffer_pkg::*;
#(
    parameter int ADDR_W = MSU_BUF_ADDR_W,
    parameter int DATA_W = MSU_BUF_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_clr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = msu_buf_depth(ADDR_W);

    // Zero start values model the simulation power-up state; hardware contents are undefined.
    logic [DATA_W-1:0] mem [0:DEPTH-1] = '{default: '0};
    logic [DATA_W-1:0] rd_data_q = '0;
    logic [DATA_W-1:0] rd_data_d;

    always_comb begin
        rd_data_d = '0;
        if (!rd_clr) begin
            rd_data_d = mem[rd_addr];
        end
    end

    // The read samples the array before this edge's write lands, giving read-first on collisions.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/msu_data_buffer.sv
// 16 KiB MSU-1 data window: port A is loaded by the program path, port B streams to the SNES.
// Reset clears only the read register; memory contents survive and port A keeps writing.
module msu_data_buffer
    import msu_data_buffer_pkg::*;
#(
    parameter int ADDR_W = MSU_BUF_ADDR_W,
    parameter int DATA_W = MSU_BUF_DATA_W
) (
    input  logic              clkin,
    input  logic              rst_n,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    input  logic [ADDR_W-1:0] addrb,
    output logic [DATA_W-1:0] doutb
);

    logic rd_clr;

    assign rd_clr = ~rst_n;

    msu_bram_sdp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bram (
        .clk     (clkin),
        .we      (wea),
        .wr_addr (addra),
        .wr_data (dina),
        .rd_clr  (rd_clr),
        .rd_addr (addrb),
        .rd_data (doutb)
    );

endmodule

// File: tb/tb_msu_data_buffer.sv
// Directed bench for msu_data_buffer: write/read, boundaries, gating, collision, streaming, reset.
module tb_msu_data_buffer;

    logic        clkin;
    logic        rst_n;
    logic        wea;
    logic [13:0] addra;
    logic [7:0]  dina;
    logic [13:0] addrb;
    logic [7:0]  doutb;

    int checks;
    int failures;
    logic [7:0] exp_q[$];

    msu_data_buffer dut (
        .clkin (clkin),
        .rst_n (rst_n),
        .wea   (wea),
        .addra (addra),
        .dina  (dina),
        .addrb (addrb),
        .doutb (doutb)
    );

    // Clock and reset defaults
    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    // One rising edge, then settle; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clkin);
        #1;
    endtask

    task automatic write_byte(input logic [13:0] a, input logic [7:0] d);
        wea   = 1'b1;
        addra = a;
        dina  = d;
        step();
        wea   = 1'b0;
    endtask

    task automatic check(input string tag, input logic [7:0] exp);
        checks++;
        assert (doutb === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, doutb, exp);
        end
    endtask

    // Presents addrb, clocks once, then checks the value popped from the expected queue.
    task automatic read_check(input string tag, input logic [13:0] a, input logic [7:0] exp);
        addrb = a;
        exp_q.push_back(exp);
        step();
        check(tag, exp_q.pop_front());
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        wea      = 1'b0;
        addra    = '0;
        dina     = '0;
        addrb    = '0;

        step();
        step();
        step();
        check("reset_doutb", 8'h00);

        // Port A is not gated by reset
        write_byte(14'h0300, 8'h77);
        check("reset_hold", 8'h00);
        rst_n = 1'b1;

        write_byte(14'h0000, 8'hA5);
        read_check("basic_0000", 14'h0000, 8'hA5);

        write_byte(14'h3FFF, 8'h5A);
        write_byte(14'h0000, 8'h11);
        read_check("bound_3fff", 14'h3FFF, 8'h5A);
        read_check("bound_0000", 14'h0000, 8'h11);
        read_check("bound_1fff", 14'h1FFF, 8'h00);

        write_byte(14'h0100, 8'h33);
        wea   = 1'b0;
        addra = 14'h0100;
        dina  = 8'hFF;
        step();
        read_check("wea_gate", 14'h0100, 8'h33);

        read_check("write_in_reset", 14'h0300, 8'h77);

        // Collision: old data first, new data on the following read
        write_byte(14'h0200, 8'h10);
        wea   = 1'b1;
        addra = 14'h0200;
        dina  = 8'h20;
        addrb = 14'h0200;
        step();
        wea = 1'b0;
        check("collide_old", 8'h10);
        step();
        check("collide_new", 8'h20);

        for (int i = 0; i < 8; i++) begin
            write_byte(14'h1000 + 14'(i), 8'(i));
        end
        for (int i = 0; i < 8; i++) begin
            read_check($sformatf("stream_%0d", i), 14'h1000 + 14'(i), 8'(i));
        end

        // Reset in the middle of a stream
        read_check("restream_0", 14'h1000, 8'h00);
        read_check("restream_1", 14'h1001, 8'h01);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            addrb = 14'h1002 + 14'(i);
            step();
            check($sformatf("mid_reset_%0d", i), 8'h00);
        end
        rst_n = 1'b1;
        read_check("post_reset_1003", 14'h1003, 8'h03);
        read_check("post_reset_3fff", 14'h3FFF, 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/msu_data_buffer.md
Name: msu_data_buffer

Overview:
- 16 KiB simple dual-port byte RAM holding the MSU-1 data stream window.
- Port A is the write side, fed by the host/MCU program-load path (pgm_address/pgm_data).
- Port B is the read side, addressed by the MSU data pointer; its output is returned to the SNES on reads of MSU register 1.
- Single clock domain; implementation must infer block RAM.

Parameters:
- ADDR_W, 14, address width of both ports (depth = 2**ADDR_W = 16384).
- DATA_W, 8, data width of both ports.

Ports:
- clkin  input  1  system clock, all logic on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- wea  input  1  port A write enable, active-high.
- addra  input  ADDR_W  port A write address.
- dina  input  DATA_W  port A write data.
- addrb  input  ADDR_W  port B read address.
- doutb  output  DATA_W  port B registered read data.

Behaviour:
- Write path:
  - At the rising edge of clkin with wea=1, mem[addra] <= dina.
  - wea=0 leaves memory unchanged.
  - Writes are accepted during reset as well; reset does not gate port A.
- Read path:
  - Synchronous, one-cycle latency: doutb at edge N+1 equals mem[addrb sampled at edge N].
  - doutb is updated every cycle; there is no read enable.
  - A new addrb each cycle gives back-to-back streaming at one byte per clock.
- Reset:
  - While rst_n=0 at a rising edge, doutb <= 0.
  - Memory contents are never cleared by reset.
  - The first valid read data appears one edge after rst_n returns to 1.
- Power-up state:
  - Memory contents are undefined in hardware.
  - For simulation, memory is zero-initialised and doutb starts at 0.
- Collision (wea=1 and addra==addrb on the same edge):
  - Read-first: doutb returns the old contents.
  - The new value is visible on the following read of that address.
- Address handling:
  - Full 14-bit decode, no aliasing; 0x0000 and 0x3FFF are both valid.
  - Address wrap is the caller's responsibility.
- No X propagation: with an out-of-range parameter combination the design must still elaborate. Depth is always exactly 2**ADDR_W.
- Timing: no combinational path from any input to doutb.

Decomposition:
- Shared package holds:
  - MSU_BUF_ADDR_W = 14
  - MSU_BUF_DATA_W = 8
  - MSU_BUF_DEPTH = 16384
- Optional single sub-module msu_bram_sdp:
  - Generic inferred simple-dual-port RAM array with registered read, read-first collision behaviour.
  - msu_data_buffer wraps it and adds the doutb reset-clear register logic.
- No state machine.

Test Plan:
- Basic write/read: reset, write 0xA5 to 0x0000 (wea=1 one cycle), then addrb=0x0000 -> doutb=0xA5 exactly one edge after addrb is sampled.
- Boundary: write 0x5A to 0x3FFF and 0x11 to 0x0000 -> reading 0x3FFF gives 0x5A; reading 0x0000 still gives 0x11 (no aliasing).
- Write enable gating: mem[0x0100]=0x33, then drive dina=0xFF with wea=0 to 0x0100 -> read 0x0100 returns 0x33.
- Collision: mem[0x0200]=0x10; same edge write 0x20 to 0x0200 and addrb=0x0200 -> doutb=0x10 next cycle; re-read -> 0x20.
- Streaming: fill 0x1000..0x1007 with 0x00..0x07, increment addrb each cycle -> doutb yields 0x00..0x07 on consecutive cycles, one-cycle lag.
- Reset mid-operation: while streaming, assert rst_n=0 for 3 cycles -> doutb=0x00 those cycles. Release and read 0x1003 -> 0x03 (contents preserved).
